// File: rtl/sysmem_responder.sv
// sysmem_responder: single-port 16-bit system memory that answers the vector
// processor's memory bus. It does one access per Clk1 edge and has no wait
// states. It also tracks 16-word sequential bursts and raises sticky flags
// for protocol and address errors.
// Optional feature: define SYSMEM_STATS_EN to add the RdCnt/WrCnt access counters.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | no request sampled on the last edge
// S_RD_ACT | read (RD=1, WR=0) sampled on the last edge
// S_WR_ACT | write (RD=0, WR=1) sampled on the last edge
// S_ERR    | RD and WR sampled together; no memory access

module sysmem_responder #(
   parameter int ADDR_W = 10
) (
   input  logic        Clk1,
   input  logic        Reset,
   input  logic [15:0] Addr,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] DataWr,
   output logic [15:0] DataRd,
   output logic        Busy,
   output logic        Burst16,
   output logic        ProtErr,
   output logic        OorErr
`ifdef SYSMEM_STATS_EN
   ,
   output logic [15:0] RdCnt,
   output logic [15:0] WrCnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RD_ACT = 2'd1,
      S_WR_ACT = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   localparam int DEPTH = 1 << ADDR_W;

   // prevType encoding: 0 = read, 1 = write
   localparam logic TYPE_RD = 1'b0;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_mem [DEPTH];
   logic [15:0] r_data_rd;
   logic        r_burst16;
   logic        r_prot_err;
   logic        r_oor_err;
   logic [15:0] r_prev_addr;
   logic        r_prev_type;
   logic [4:0]  r_run_len;

   logic        w_rd_acc;
   logic        w_wr_acc;
   logic        w_err;
   logic        w_oor;
   logic        w_seq;
   logic [15:0] w_prev_addr_inc;
   logic [ADDR_W-1:0] w_idx;

   assign w_rd_acc        = RD & ~WR;
   assign w_wr_acc        = WR & ~RD;
   assign w_err           = RD & WR;
   assign w_oor           = (Addr >> ADDR_W) != 16'd0;
   assign w_idx           = Addr[ADDR_W-1:0];
   assign w_prev_addr_inc = r_prev_addr + 16'd1;
   // The type comparison uses WR, so it only means something on a single-type access.
   assign w_seq           = (WR == r_prev_type) && (Addr == w_prev_addr_inc);

   // State register
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state follows the sampled request pair on every edge; ERR is not sticky
   always_comb begin
      w_state_nxt = S_IDLE;
      case ({RD, WR})
         2'b10:   w_state_nxt = S_RD_ACT;
         2'b01:   w_state_nxt = S_WR_ACT;
         2'b11:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Memory array write port; contents survive reset, and a reset edge blocks the write
   always_ff @(posedge Clk1) begin
      if (!Reset && w_wr_acc && !w_oor) begin
         r_mem[w_idx] <= DataWr;
      end
   end

   // Read data, sticky error flags and burst run tracking
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         r_data_rd   <= 16'h0000;
         r_burst16   <= 1'b0;
         r_prot_err  <= 1'b0;
         r_oor_err   <= 1'b0;
         r_run_len   <= 5'd0;
         r_prev_addr <= 16'h0000;
         r_prev_type <= TYPE_RD;
      end else begin
         r_burst16 <= 1'b0;
         if (w_err) begin
            r_prot_err <= 1'b1;
            r_run_len  <= 5'd0;
         end else if (w_rd_acc || w_wr_acc) begin
            if (w_oor) begin
               r_oor_err <= 1'b1;
            end
            if (w_rd_acc) begin
               r_data_rd <= w_oor ? 16'h0000 : r_mem[w_idx];
            end
            r_prev_addr <= Addr;
            r_prev_type <= w_wr_acc;
            // An out-of-range access still counts toward the run, so 16'hFFFF -> 16'h0000 continues a burst.
            if (w_seq) begin
               if (r_run_len == 5'd15) begin
                  r_run_len <= 5'd0;
                  r_burst16 <= 1'b1;
               end else begin
                  r_run_len <= r_run_len + 5'd1;
               end
            end else begin
               r_run_len <= 5'd1;
            end
         end else begin
            r_run_len <= 5'd0;
         end
      end
   end

`ifdef SYSMEM_STATS_EN
   logic [15:0] r_rd_cnt;
   logic [15:0] r_wr_cnt;

   // Saturating counts of accepted in-range accesses
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         r_rd_cnt <= 16'h0000;
         r_wr_cnt <= 16'h0000;
      end else begin
         if (w_rd_acc && !w_oor && (r_rd_cnt != 16'hFFFF)) begin
            r_rd_cnt <= r_rd_cnt + 16'd1;
         end
         if (w_wr_acc && !w_oor && (r_wr_cnt != 16'hFFFF)) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
         end
      end
   end

   assign RdCnt = r_rd_cnt;
   assign WrCnt = r_wr_cnt;
`endif

   assign DataRd  = r_data_rd;
   assign Busy    = (r_state == S_RD_ACT) || (r_state == S_WR_ACT);
   assign Burst16 = r_burst16;
   assign ProtErr = r_prot_err;
   assign OorErr  = r_oor_err;

endmodule

// File: tb/tb_sysmem_responder.sv
// Self-checking bench for sysmem_responder (ADDR_W = 10).
// Expected read data is pushed to a scoreboard queue when a read is driven,
// and popped and compared after the edge that returns it.
module tb_sysmem_responder;

   logic        Clk1 = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] Addr = 16'h0000;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic [15:0] DataWr = 16'h0000;
   logic [15:0] DataRd;
   logic        Busy;
   logic        Burst16;
   logic        ProtErr;
   logic        OorErr;
`ifdef SYSMEM_STATS_EN
   logic [15:0] RdCnt;
   logic [15:0] WrCnt;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] m_mem [1024];
   logic [15:0] exp_q [$];
   logic [15:0] last_rd = 16'h0000;

   sysmem_responder #(.ADDR_W(10)) dut (
      .Clk1    (Clk1),
      .Reset   (Reset),
      .Addr    (Addr),
      .RD      (RD),
      .WR      (WR),
      .DataWr  (DataWr),
      .DataRd  (DataRd),
      .Busy    (Busy),
      .Burst16 (Burst16),
      .ProtErr (ProtErr),
      .OorErr  (OorErr)
`ifdef SYSMEM_STATS_EN
      ,
      .RdCnt   (RdCnt),
      .WrCnt   (WrCnt)
`endif
   );

   always #5 Clk1 = ~Clk1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // One bus cycle: drive, step one edge, check data via the scoreboard plus Busy and Burst16
   task automatic do_cyc(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic exp_b);
      logic oor;
      logic [15:0] exp_d;
      oor = (a[15:10] != 6'd0);
      RD = rd; WR = wr; Addr = a; DataWr = d;
      if (rd && !wr) exp_q.push_back(oor ? 16'h0000 : m_mem[a[9:0]]);
      if (wr && !rd && !oor) m_mem[a[9:0]] = d;
      @(posedge Clk1); #1;
      if (rd && !wr) begin
         if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            exp_d = exp_q.pop_front();
            last_rd = exp_d;
         end
      end
      chk("data_rd", {16'h0, DataRd}, {16'h0, last_rd});
      chk("busy", {31'h0, Busy}, {31'h0, rd ^ wr});
      chk("burst16", {31'h0, Burst16}, {31'h0, exp_b});
   endtask

   task automatic do_reset(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
      Reset = 1'b1; RD = rd; WR = wr; Addr = a; DataWr = d;
      @(posedge Clk1); #1;
      Reset = 1'b0; RD = 1'b0; WR = 1'b0;
      last_rd = 16'h0000;
      exp_q.delete();
      chk("rst_data_rd", {16'h0, DataRd}, 32'h0);
      chk("rst_busy", {31'h0, Busy}, 32'h0);
      chk("rst_burst16", {31'h0, Burst16}, 32'h0);
      chk("rst_prot_err", {31'h0, ProtErr}, 32'h0);
      chk("rst_oor_err", {31'h0, OorErr}, 32'h0);
      chk("rst_run_len", {27'h0, dut.r_run_len}, 32'h0);
   endtask

   initial begin
      @(posedge Clk1); #1;
      do_reset(1'b1, 1'b1, 16'h0400, 16'h0000);

      // A write held across a reset edge must be dropped
      do_cyc(1'b0, 1'b1, 16'h0006, 16'h6666, 1'b0);
      do_reset(1'b0, 1'b1, 16'h0006, 16'hDEAD);
      do_cyc(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0);

      // Basic write then read
      do_cyc(1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
      do_cyc(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
      chk("basic_rd", {16'h0, DataRd}, 32'h0000BEEF);

      // 16-word write burst, then read burst, then a repeated read
      for (int i = 0; i < 16; i++)
         do_cyc(1'b0, 1'b1, 16'h0100 + 16'(i), 16'h0100 + 16'(i), i == 15);
      for (int i = 0; i < 16; i++)
         do_cyc(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0000, i == 15);
      do_cyc(1'b1, 1'b0, 16'h010F, 16'h0000, 1'b0);
      do_cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Protocol error: no access, DataRd holds, ProtErr sticks through idle
      do_cyc(1'b0, 1'b1, 16'h0003, 16'h1234, 1'b0);
      do_cyc(1'b0, 1'b1, 16'h0004, 16'hAAAA, 1'b0);
      do_cyc(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
      do_cyc(1'b1, 1'b1, 16'h0003, 16'h9999, 1'b0);
      chk("prot_err_set", {31'h0, ProtErr}, 32'h1);
      chk("prot_data_hold", {16'h0, DataRd}, 32'h0000AAAA);
      do_cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("prot_err_sticky", {31'h0, ProtErr}, 32'h1);
      do_cyc(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
      chk("prot_mem3", {16'h0, DataRd}, 32'h00001234);
      chk("oor_clear", {31'h0, OorErr}, 32'h0);

      // Out-of-range write dropped and read returns zero
      do_cyc(1'b0, 1'b1, 16'h0000, 16'h0C0C, 1'b0);
      do_cyc(1'b0, 1'b1, 16'h0400, 16'h5555, 1'b0);
      chk("oor_set", {31'h0, OorErr}, 32'h1);
      do_cyc(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0);
      chk("oor_rd_zero", {16'h0, DataRd}, 32'h0);
      do_cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("oor_mem0", {16'h0, DataRd}, 32'h00000C0C);

      // Address wrap counts as sequential
      do_cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      do_cyc(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
      do_cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("wrap_run_len", {27'h0, dut.r_run_len}, 32'd2);
      chk("wrap_oor", {31'h0, OorErr}, 32'h1);

      // Reset mid-burst: the old count is lost, and a new run of 16 fires
      for (int i = 0; i < 8; i++)
         do_cyc(1'b0, 1'b1, 16'h0110 + 16'(i), 16'hA000 + 16'(i), 1'b0);
      do_cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 8; i++)
         do_cyc(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0000, 1'b0);
      do_reset(1'b1, 1'b0, 16'h0108, 16'h0000);
      for (int i = 0; i < 16; i++)
         do_cyc(1'b1, 1'b0, 16'h0108 + 16'(i), 16'h0000, i == 15);
      do_cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

`ifdef SYSMEM_STATS_EN
      do_reset(1'b0, 1'b0, 16'h0000, 16'h0000);
      do_cyc(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
      do_cyc(1'b0, 1'b1, 16'h0020, 16'h0020, 1'b0);
      do_cyc(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
      do_cyc(1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0);
      do_cyc(1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0);
      do_cyc(1'b0, 1'b1, 16'h0800, 16'h0001, 1'b0);
      do_cyc(1'b0, 1'b1, 16'h0021, 16'h0021, 1'b0);
      do_cyc(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
      chk("rd_cnt", {16'h0, RdCnt}, 32'd3);
      chk("wr_cnt", {16'h0, WrCnt}, 32'd2);
`endif

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sysmem_responder.md
# sysmem_responder

Single-port 16-bit system memory that services the vector processor's memory bus as the responder. The processor drives `Addr`, `RD`, `WR` and write data; this block returns read data. It sits between the processor core and the board-level memory model or test harness. It also tracks sequential bursts, which are the 16-word VLD/VST transfers, and flags protocol errors.

## Interface
- `ADDR_W`, default 10: number of implemented word-address bits. Depth is 2^ADDR_W words of 16 bits.
- `Clk1` in 1: clock. All state updates on posedge Clk1.
- `Reset` in 1: synchronous, active-high.
- `Addr` in 16: word address from the processor.
- `RD` in 1: read request, level.
- `WR` in 1: write request, level.
- `DataWr` in 16: write data (processor DataOut).
- `DataRd` out 16: read data (processor DataIn), registered.
- `Busy` out 1: high while in RD_ACT or WR_ACT.
- `Burst16` out 1: one-cycle pulse on the 16th consecutive sequential access of the same type.
- `ProtErr` out 1: sticky. Set when RD and WR are sampled high together.
- `OorErr` out 1: sticky. Set on any access with `Addr[15:ADDR_W]` != 0.
- `RdCnt` out 16, `WrCnt` out 16: present only with `SYSMEM_STATS_EN`.

## Operation
- **States:** IDLE, RD_ACT, WR_ACT, ERR. The state is re-evaluated every Clk1 edge from the sampled `RD`/`WR`:
  - RD=1, WR=0 → RD_ACT
  - RD=0, WR=1 → WR_ACT
  - RD=1, WR=1 → ERR
  - RD=0, WR=0 → IDLE
  - ERR returns by the same rules on the next edge. ERR itself is not sticky; `ProtErr` is.
- **Read:** on an edge sampling RD=1, WR=0 with an in-range address, `DataRd` <= mem[Addr[ADDR_W-1:0]].
  - Out-of-range read: `DataRd` <= 16'h0000 and `OorErr` is set.
  - When not reading, `DataRd` holds its last value.
- **Write:** on an edge sampling WR=1, RD=0 with an in-range address, mem[Addr] <= `DataWr`.
  - Out-of-range write is dropped and `OorErr` is set.
- **ERR cycle:** no memory access, `DataRd` holds, `ProtErr` <= 1.
- **Burst tracking:**
  - Registers: `prevAddr` (16 bits), `prevType`, `runLen` (5 bits).
  - An access is sequential when its type equals `prevType` and `Addr == prevAddr + 1` (mod 2^16, so 16'hFFFF→16'h0000 counts).
  - Sequential access: `runLen` increments. Non-sequential access: `runLen` <= 1. An IDLE or ERR cycle clears `runLen` to 0.
  - `Burst16` pulses for one cycle on the edge where `runLen` becomes 16. `runLen` then reloads to 0, so a continued stream produces a pulse every 16 accesses.
  - A repeated access to the same address is non-sequential; this covers the RD that VLD holds across its done state.
- **Memory contents** are not cleared by reset.

## Timing
- **Read latency:** 1 Clk1 edge. `DataRd` is valid after the edge that sampled RD and is stable until the next read edge.
- **Write:** committed on the sampling edge. A read of the same address on the following edge returns the new data.
- **Back-to-back accesses:** one access per Clk1 edge, no wait states, no handshake. `Busy` is informational only.
- **Reset values:** state=IDLE, `DataRd`=0, `Busy`=0, `Burst16`=0, `ProtErr`=0, `OorErr`=0, `runLen`=0, `prevAddr`=0, `prevType`=read, counters=0.
- **Reset with RD or WR high:** reset wins. No memory access occurs on that edge and no flags are set.
- **Reset mid-burst:** `runLen` is cleared, so the next access starts a new run at 1.

## Configuration
- `SYSMEM_STATS_EN` defined: `RdCnt` and `WrCnt` ports exist.
  - Each counts accepted in-range reads or writes.
  - ERR and out-of-range accesses are excluded.
  - Counters saturate at 16'hFFFF and clear on reset.
- `SYSMEM_STATS_EN` undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- **Basic write/read:** write 16'hBEEF to 0x0005, then RD 0x0005 → `DataRd`=16'hBEEF after 1 edge. `Busy` is high for both cycles.
- **Burst:** WR 16 consecutive words 0x0100–0x010F (data = address) → `Burst16` pulses once on the 16th edge. Then RD the same 16 addresses → second pulse with matching data. RD held at 0x010F one extra cycle → no pulse.
- **Protocol error:** RD=WR=1 at 0x0003 holding 16'h1234, with prior `DataRd`=16'hAAAA → `ProtErr`=1, mem[3] unchanged, `DataRd` stays 16'hAAAA. The following IDLE keeps `ProtErr`=1.
- **Out-of-range (ADDR_W=10):** WR 16'h5555 to 0x0400 → mem[0] unchanged and `OorErr`=1. RD 0x0400 → `DataRd`=0.
- **Address wrap:** RD 0xFFFF then 0x0000 → `runLen` is 2, with `OorErr` set by 0xFFFF.
- **Reset mid-burst plus stats:** Reset after 8 sequential reads → `runLen`=0 and `Burst16` does not fire at the old count. With `SYSMEM_STATS_EN`, 3 reads plus 2 writes → `RdCnt`=3, `WrCnt`=2.
